seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the clock/alarm multiplexed 7-segment display drive. It samples the active-low segment bus and one-hot digit-select bus, and reconstructs the six displayed BCD digits (HH:MM:SS) from the scan. It publishes one validated time snapshot per complete scan frame. Used as an on-chip display read-back monitor and as the bench scoreboard front end for the clock block.

Parameters:
SETTLE_CYC, 4, consecutive identical clk samples needed to accept a digit; legal range 2..255.
TIMEOUT_CYC, 4096, clk cycles without an accepted digit before the partial frame is discarded and stale is raised.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
seg_in  in  7  segment bus, active-low, bit order gfedcba (0 = 1000000, 9 = 0010000)
sel_in  in  6  digit select, one-hot: bit0 hour tens, bit1 hour units, bit2 min tens, bit3 min units, bit4 sec tens, bit5 sec units
hour_bcd  out  8  {tens,units} of the last frame
min_bcd  out  8  {tens,units} of the last frame
sec_bcd  out  8  {tens,units} of the last frame
frame_valid  out  1  one-cycle pulse when the *_bcd outputs update
frame_err  out  1  qualifies the last frame; held until the next frame
stale  out  1  level; scan activity lost

Behaviour:
- Reset: all outputs 0, digit slots and capture/bad masks cleared, all counters 0. Reset mid-frame discards the partial frame.
- Input sync: 2-flop synchronizer on seg_in and sel_in, 2-cycle latency. Comparisons use synced values plus a third "previous" register.
- Settle counter: if synced {sel,seg} equals previous and sel is exactly one-hot, then cnt increments, saturating at SETTLE_CYC. Any change, or a non-one-hot sel (zero or multiple bits), forces cnt to 0.
- Capture pulse: fires on the cycle cnt goes from SETTLE_CYC-1 to SETTLE_CYC. It fires once per stable period, so captures are at least SETTLE_CYC cycles apart.
- On capture: slot[idx] <= decode(seg), cap_mask[idx] <= 1, bad[idx] <= (pattern not one of the ten digit codes). An invalid pattern is stored as 4'hF.
- Recapturing a slot already set in the current frame overwrites it (newest wins). This is not an error.
- Frame complete: on the cycle after cap_mask becomes 6'b111111:
  - frame_valid = 1 for one cycle;
  - *_bcd load from the slots;
  - frame_err = |bad OR range error;
  - cap_mask and bad clear.
- Range error: hour tens > 2, hour > 23, min tens > 5, or sec tens > 5. Checked only when none of the digits in that field are bad.
- Capture order is irrelevant, so both the 100000→000001 scan order and the reverse are accepted.
- Timeout: idle counter resets on every capture and otherwise increments. When it reaches TIMEOUT_CYC: stale <= 1, cap_mask and bad clear, counter holds. stale clears on the next capture; *_bcd keep their last values.
- A capture and a frame-complete cannot fall on the same cycle (SETTLE_CYC >= 2), so no arbitration is needed.
- No output is combinational from inputs.

Decomposition:
- Shared package holds:
  - the ten segment-pattern constants (active-low gfedcba);
  - digit index constants HT, HU, MT, MU, ST, SU, aligned to the sel bit positions;
  - BCD_INVALID = 4'hF;
  - NUM_DIGITS = 6;
  - the pattern-to-BCD decode function.
- One natural sub-module: seg7_to_bcd. It is combinational: seg[6:0] in, bcd[3:0] and invalid out. The parent uses a single instance on the synced bus.

Test Plan:
- Clean frame for 07:50:00, each digit held 10 cycles, order sel 100000→000001, SETTLE_CYC=4 → one frame_valid pulse; hour_bcd=8'h07, min_bcd=8'h50, sec_bcd=8'h00, frame_err=0.
- Same frame with min units seg=7'b1111111 → frame_valid, min_bcd=8'h5F, frame_err=1. Next clean frame → frame_err=0.
- Frame 25:30:59 (hour tens 2, units 5) → hour_bcd=8'h25, frame_err=1. Frame 23:59:59 → frame_err=0.
- Glitches:
  - hour units held only 3 cycles, then the frame completes without it → no frame_valid;
  - sel=6'b000011 held 20 cycles → no capture, cnt stays 0.
- Four digits captured, then inputs frozen with sel=0 for 4096 cycles → stale=1, no frame_valid. A full frame then gives stale=0 after the first capture and frame_valid with new values.
- rst pulsed after three captures, followed by the remaining three digits → no frame_valid; all outputs 0 until a full six-digit frame arrives.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// rtl/seg7_scan_decoder_pkg.sv - shared constants, types and segment decode for the scan decoder
package seg7_scan_decoder_pkg;

  localparam int NUM_DIGITS = 6;

  // Digit slot indices, aligned with the sel bus bit positions
  localparam int HT = 0;
  localparam int HU = 1;
  localparam int MT = 2;
  localparam int MU = 3;
  localparam int ST = 4;
  localparam int SU = 5;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef struct packed {
    logic       invalid;
    logic [3:0] bcd;
  } bcd_dec_t;

  // Map a segment pattern to its BCD value; anything else is flagged and reads as BCD_INVALID
  function automatic bcd_dec_t seg_decode(input logic [6:0] seg);
    bcd_dec_t d;
    d.invalid = 1'b0;
    d.bcd     = BCD_INVALID;
    case (seg)
      SEG_0:   d.bcd = 4'd0;
      SEG_1:   d.bcd = 4'd1;
      SEG_2:   d.bcd = 4'd2;
      SEG_3:   d.bcd = 4'd3;
      SEG_4:   d.bcd = 4'd4;
      SEG_5:   d.bcd = 4'd5;
      SEG_6:   d.bcd = 4'd6;
      SEG_7:   d.bcd = 4'd7;
      SEG_8:   d.bcd = 4'd8;
      SEG_9:   d.bcd = 4'd9;
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_seg7_to_bcd.sv
// rtl/seg7_scan_decoder_seg7_to_bcd.sv - combinational segment pattern to BCD decoder
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       invalid
);

  bcd_dec_t dec;

  // Pure table lookup; invalid patterns come out as BCD_INVALID with the flag set
  always_comb begin
    dec = seg_decode(seg);
  end

  assign bcd     = dec.bcd;
  assign invalid = dec.invalid;

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds HH:MM:SS from a multiplexed 7-segment scan
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [5:0] sel_in,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       stale
);

  localparam int         IDLE_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] CNT_MAX  = 8'(SETTLE_CYC);
  localparam logic [7:0] CNT_PRE  = 8'(SETTLE_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

  logic [6:0] seg_s1, seg_s2, seg_prev;
  logic [5:0] sel_s1, sel_s2, sel_prev;

  logic [7:0] cnt;
  logic       sel_one_hot;
  logic       sample_same;
  logic       stable;
  logic       capture;
  logic [2:0] idx;

  logic [3:0] dec_bcd;
  logic       dec_invalid;

  logic [3:0] slot [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [NUM_DIGITS-1:0] bad;
  logic                  frame_full;

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_hit;

  logic hour_bad, min_bad, sec_bad;
  logic range_err;

  // Two-flop synchronizer plus one history stage used for stability comparison
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      seg_prev <= '0;
      sel_s1   <= '0;
      sel_s2   <= '0;
      sel_prev <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= sel_in;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
    end
  end

  // A sample is stable when it repeats and selects exactly one digit
  always_comb begin
    sel_one_hot = (sel_s2 != 6'd0) && ((sel_s2 & (sel_s2 - 6'd1)) == 6'd0);
    sample_same = ({sel_s2, seg_s2} == {sel_prev, seg_prev});
    stable      = sel_one_hot && sample_same;
    capture     = stable && (cnt == CNT_PRE);
  end

  // Settle counter saturates so a long hold produces only one capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!stable) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Slot index from the one-hot select; only meaningful when capture is set
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_s2[i]) idx = 3'(i);
    end
  end

  seg7_to_bcd u_dec (
    .seg     (seg_s2),
    .bcd     (dec_bcd),
    .invalid (dec_invalid)
  );

  assign frame_full = (cap_mask == {NUM_DIGITS{1'b1}});
  assign idle_hit   = (idle_cnt == IDLE_MAX);

  // Digit storage; a later capture of the same slot overwrites the earlier one
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot[i] <= '0;
    end else if (capture) begin
      slot[idx] <= dec_bcd;
    end
  end

  // Capture and bad masks; cleared when a frame is published or the scan goes idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_mask <= '0;
      bad      <= '0;
    end else if (capture) begin
      cap_mask[idx] <= 1'b1;
      bad[idx]      <= dec_invalid;
    end else if (frame_full || idle_hit) begin
      cap_mask <= '0;
      bad      <= '0;
    end
  end

  // Idle counter restarts on each capture and parks at the timeout value
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (capture) begin
      idle_cnt <= '0;
    end else if (!idle_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Stale flag: raised by the idle timeout, dropped by the next accepted digit
  always_ff @(posedge clk) begin
    if (rst) begin
      stale <= 1'b0;
    end else if (capture) begin
      stale <= 1'b0;
    end else if (idle_hit) begin
      stale <= 1'b1;
    end
  end

  // Range rules only apply to fields whose digits all decoded cleanly
  always_comb begin
    hour_bad  = bad[HT] | bad[HU];
    min_bad   = bad[MT] | bad[MU];
    sec_bad   = bad[ST] | bad[SU];
    range_err = 1'b0;
    if (!hour_bad && ((slot[HT] > 4'd2) || ((slot[HT] == 4'd2) && (slot[HU] > 4'd3))))
      range_err = 1'b1;
    if (!min_bad && (slot[MT] > 4'd5))
      range_err = 1'b1;
    if (!sec_bad && (slot[ST] > 4'd5))
      range_err = 1'b1;
  end

  // Publish the snapshot one cycle after the last missing digit arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      hour_bcd    <= '0;
      min_bcd     <= '0;
      sec_bcd     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= frame_full;
      if (frame_full) begin
        hour_bcd  <= {slot[HT], slot[HU]};
        min_bcd   <= {slot[MT], slot[MU]};
        sec_bcd   <= {slot[ST], slot[SU]};
        frame_err <= (|bad) | range_err;
      end
    end
  end

endmodule
